// File: rtl/skinny_sbox_hpc2_lanes_if.sv
`default_nettype none
// ============================================================================
// Module      : skinny_sbox_hpc2_lanes_if
// Description : Handshake/data bundle between the masked state register,
//               the masked SKINNY-64 S-box array and the linear layer.
// Revision    : 1.0 - initial release
// ============================================================================
interface skinny_sbox_hpc2_lanes_if #(
  parameter int ORDER = 1,
  parameter int LANES = 16
) ();
  localparam int SHARES = ORDER + 1;
  localparam int RND_W  = LANES * 4 * ORDER * (ORDER + 1) / 2;
  localparam int DW     = 4 * LANES * SHARES;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] X_s;
  logic [RND_W-1:0] Fresh;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] Y_s;
  logic [2:0]    occupancy;

  // Producer / consumer side (round core, testbench)
  modport master (
    output in_valid, X_s, Fresh, out_ready,
    input  in_ready, out_valid, Y_s, occupancy
  );

  // S-box array side
  modport slave (
    input  in_valid, X_s, Fresh, out_ready,
    output in_ready, out_valid, Y_s, occupancy
  );
endinterface
`default_nettype wire

// File: rtl/skinny_sbox_hpc2_lanes.sv
`default_nettype none
// ============================================================================
// Module      : skinny_sbox_hpc2_lanes
// Description : LANES parallel masked SKINNY-64 S-boxes built from HPC2 AND
//               gadgets at arbitrary order. Five enable-gated pipeline
//               stages, valid/ready handshake, global stall on back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// HPC2 AND gadget: one register stage inside, output is a share-local XOR of
// registered terms. Every internal register holds when en_i is low.
// ----------------------------------------------------------------------------
module skinny_hpc2_and #(
  parameter int SHARES = 2,
  parameter int PAIRS  = SHARES * (SHARES - 1) / 2
) (
  input  wire logic              clk,
  input  wire logic              en_i,
  input  wire logic [SHARES-1:0] a_i,
  input  wire logic [SHARES-1:0] b_i,
  input  wire logic [PAIRS-1:0]  r_i,
  output logic      [SHARES-1:0] c_o
);
  // Index of the shared random bit r_ij = r_ji in the (i<j) enumeration
  function automatic int pair_idx(input int i, input int j);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * SHARES - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  logic [SHARES-1:0][SHARES-1:0] term;

  for (genvar i = 0; i < SHARES; i++) begin : g_row
    logic a_q;

    // a_i delayed so it meets the registered (b_j ^ r_ij) after the barrier
    always_ff @(posedge clk) begin
      if (en_i) a_q <= a_i[i];
    end

    for (genvar j = 0; j < SHARES; j++) begin : g_col
      if (i == j) begin : g_diag
        logic ab_q;

        // Own-share product, registered
        always_ff @(posedge clk) begin
          if (en_i) ab_q <= a_i[i] & b_i[j];
        end

        assign term[i][j] = ab_q;
      end else begin : g_cross
        localparam int P = pair_idx(i, j);
        logic u_q;
        logic w_q;

        // Cross-domain terms masked by r_ij before the register barrier
        always_ff @(posedge clk) begin
          if (en_i) begin
            u_q <= ~a_i[i] & r_i[P];
            w_q <= b_i[j] ^ r_i[P];
          end
        end

        assign term[i][j] = u_q ^ (a_q & w_q);
      end
    end

    assign c_o[i] = ^term[i];
  end
endmodule

// ----------------------------------------------------------------------------
// S-box array. Per lane with x = {a,b,c,d} (MSB first):
//   t3 = d ^ NOR(a,b)     t2 = a ^ NOR(b,c)          (AND layer 1)
//   t1 = b ^ NOR(c,t3)    t0 = c ^ NOR(t3,t2)        (AND layer 2)
//   y  = {t3, t2, t1, t0}
// NOR(p,q) = AND(~p,~q); masked NOT flips share 0 only.
// ----------------------------------------------------------------------------
module skinny_sbox_hpc2_lanes #(
  parameter int ORDER = 1,
  parameter int LANES = 16
) (
  input  wire logic               clk,
  input  wire logic               rst,
  skinny_sbox_hpc2_lanes_if.slave sbox_if
);
  localparam int SHARES = ORDER + 1;
  localparam int PAIRS  = ORDER * (ORDER + 1) / 2;
  localparam int RND_W  = LANES * 4 * PAIRS;
  localparam int DW     = 4 * LANES * SHARES;
  localparam logic [SHARES-1:0] NOT_MASK = SHARES'(1);

  logic          en;
  logic          in_hs;
  logic          out_hs;
  logic [4:0]    v_q, v_d;
  logic [2:0]    occ_q, occ_d;
  logic [DW-1:0] y_d, y_q;

  assign en     = ~v_q[4] | sbox_if.out_ready;
  assign in_hs  = sbox_if.in_valid & en;
  assign out_hs = v_q[4] & sbox_if.out_ready;

  assign sbox_if.in_ready  = en;
  assign sbox_if.out_valid = v_q[4];
  assign sbox_if.Y_s       = y_q;
  assign sbox_if.occupancy = occ_q;

  // Valid chain and in-flight counter next-state
  always_comb begin
    v_d   = v_q;
    occ_d = occ_q;
    if (en) v_d = {v_q[3:0], in_hs};
    case ({in_hs, out_hs})
      2'b10:   occ_d = occ_q + 3'd1;
      2'b01:   occ_d = occ_q - 3'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Control state; reset discards everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      occ_q <= '0;
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
    end
  end

  // Output register: cleared on reset, otherwise loads the last stage on enable
  always_ff @(posedge clk) begin
    if (rst)     y_q <= '0;
    else if (en) y_q <= y_d;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [SHARES-1:0] a, b, c, d;
    logic [SHARES-1:0] n1, n2, n3, n4;
    logic [SHARES-1:0] s0_a_q, s0_b_q, s0_c_q, s0_d_q;
    logic [SHARES-1:0] s1_a_q, s1_b_q, s1_c_q, s1_d_q, s1_n1_q, s1_n2_q;
    logic [SHARES-1:0] s2_t3_q, s2_t2_q, s2_b_q, s2_c_q;
    logic [SHARES-1:0] s3_t3_q, s3_t2_q, s3_b_q, s3_c_q;

    for (genvar s = 0; s < SHARES; s++) begin : g_share
      assign a[s] = sbox_if.X_s[(s * LANES + l) * 4 + 3];
      assign b[s] = sbox_if.X_s[(s * LANES + l) * 4 + 2];
      assign c[s] = sbox_if.X_s[(s * LANES + l) * 4 + 1];
      assign d[s] = sbox_if.X_s[(s * LANES + l) * 4 + 0];
      assign y_d[(s * LANES + l) * 4 +: 4] =
        {s3_t3_q[s], s3_t2_q[s], s3_b_q[s] ^ n3[s], s3_c_q[s] ^ n4[s]};
    end

    skinny_hpc2_and #(.SHARES(SHARES), .PAIRS(PAIRS)) u_and0 (
      .clk(clk), .en_i(en), .a_i(a ^ NOT_MASK), .b_i(b ^ NOT_MASK),
      .r_i(sbox_if.Fresh[(l * 4 + 0) * PAIRS +: PAIRS]), .c_o(n1)
    );
    skinny_hpc2_and #(.SHARES(SHARES), .PAIRS(PAIRS)) u_and1 (
      .clk(clk), .en_i(en), .a_i(b ^ NOT_MASK), .b_i(c ^ NOT_MASK),
      .r_i(sbox_if.Fresh[(l * 4 + 1) * PAIRS +: PAIRS]), .c_o(n2)
    );
    skinny_hpc2_and #(.SHARES(SHARES), .PAIRS(PAIRS)) u_and2 (
      .clk(clk), .en_i(en), .a_i(s2_c_q ^ NOT_MASK), .b_i(s2_t3_q ^ NOT_MASK),
      .r_i(sbox_if.Fresh[(l * 4 + 2) * PAIRS +: PAIRS]), .c_o(n3)
    );
    skinny_hpc2_and #(.SHARES(SHARES), .PAIRS(PAIRS)) u_and3 (
      .clk(clk), .en_i(en), .a_i(s2_t3_q ^ NOT_MASK), .b_i(s2_t2_q ^ NOT_MASK),
      .r_i(sbox_if.Fresh[(l * 4 + 3) * PAIRS +: PAIRS]), .c_o(n4)
    );

    // Share-wise balancing registers around the gadgets; no share mixing here
    always_ff @(posedge clk) begin
      if (en) begin
        s0_a_q  <= a;
        s0_b_q  <= b;
        s0_c_q  <= c;
        s0_d_q  <= d;
        s1_a_q  <= s0_a_q;
        s1_b_q  <= s0_b_q;
        s1_c_q  <= s0_c_q;
        s1_d_q  <= s0_d_q;
        s1_n1_q <= n1;
        s1_n2_q <= n2;
        s2_t3_q <= s1_d_q ^ s1_n1_q;
        s2_t2_q <= s1_a_q ^ s1_n2_q;
        s2_b_q  <= s1_b_q;
        s2_c_q  <= s1_c_q;
        s3_t3_q <= s2_t3_q;
        s3_t2_q <= s2_t2_q;
        s3_b_q  <= s2_b_q;
        s3_c_q  <= s2_c_q;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_skinny_sbox_hpc2_lanes.sv
`default_nettype none
// ============================================================================
// Module      : tb_skinny_sbox_hpc2_lanes
// Description : Self-checking bench for the masked SKINNY-64 S-box array,
//               first-order 16-lane instance plus a second-order 4-lane one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_skinny_sbox_hpc2_lanes;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  skinny_sbox_hpc2_lanes_if #(.ORDER(1), .LANES(16)) bus ();
  skinny_sbox_hpc2_lanes_if #(.ORDER(2), .LANES(4))  bus2 ();

  skinny_sbox_hpc2_lanes #(.ORDER(1), .LANES(16)) u_dut (
    .clk(clk), .rst(rst), .sbox_if(bus)
  );
  skinny_sbox_hpc2_lanes #(.ORDER(2), .LANES(4)) u_dut2 (
    .clk(clk), .rst(rst), .sbox_if(bus2)
  );

  logic [3:0] SB [16] = '{4'hC, 4'h6, 4'h9, 4'h0, 4'h1, 4'hA, 4'h2, 4'hB,
                          4'h3, 4'h8, 4'h5, 4'hD, 4'h4, 4'hE, 4'h7, 4'hF};

  int n_pass = 0, n_fail = 0, n_total = 0;
  int cyc_no = 0, n_out = 0, first_out = -1, last_out = -1;
  logic         ov_seen, last_irdy, prev_stall;
  logic [2:0]   last_occ;
  logic [127:0] prev_y;
  logic [63:0]  q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sbox64(input logic [63:0] xv);
    logic [63:0] r;
    for (int l = 0; l < 16; l++) r[4*l +: 4] = SB[xv[4*l +: 4]];
    return r;
  endfunction

  function automatic logic [127:0] mask1(input logic [63:0] xv);
    logic [63:0] s0;
    s0 = {$urandom, $urandom};
    return {xv ^ s0, s0};
  endfunction

  function automatic logic [47:0] mask2(input logic [15:0] xv);
    logic [15:0] s0, s1;
    s0 = 16'($urandom);
    s1 = 16'($urandom);
    return {xv ^ s0 ^ s1, s1, s0};
  endfunction

  // One clock cycle on the 16-lane instance: drive, sample on negedge, score
  task automatic cyc(input logic iv, input logic [63:0] xv, input logic [127:0] xs,
                     input logic ordy, output logic acc);
    logic [63:0] fr;
    logic [63:0] yu;
    fr = {$urandom, $urandom};
    bus.in_valid  = iv;
    bus.X_s       = xs;
    bus.Fresh     = fr;
    bus.out_ready = ordy;
    @(negedge clk);
    chk("in_ready", 64'(bus.in_ready), 64'(!(bus.out_valid && !ordy)));
    chk("occupancy", 64'(bus.occupancy), 64'(q.size()));
    if (prev_stall) chk("y_hold", 64'(bus.Y_s == prev_y), 64'd1);
    if (bus.out_valid) begin
      chk("out_has_ref", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        yu = bus.Y_s[63:0] ^ bus.Y_s[127:64];
        chk("y_unmask", yu, q[0]);
      end
    end
    ov_seen    = bus.out_valid;
    last_occ   = bus.occupancy;
    last_irdy  = bus.in_ready;
    prev_stall = bus.out_valid && !ordy;
    prev_y     = bus.Y_s;
    acc        = iv && bus.in_ready;
    if (bus.out_valid && ordy) begin
      n_out++;
      if (first_out < 0) first_out = cyc_no;
      last_out = cyc_no;
      if (q.size() > 0) void'(q.pop_front());
    end
    if (acc) q.push_back(sbox64(xv));
    cyc_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_counts();
    n_out = 0;
    first_out = -1;
    last_out = -1;
    cyc_no = 0;
  endtask

  initial begin
    logic         acc;
    logic [63:0]  xv;
    logic [127:0] xs;
    logic [15:0]  xv2;
    logic [15:0]  exp2 [16];
    logic [15:0]  y2;
    logic [47:0]  fr2;
    int           lat, occ_at1, idx, idx2;

    rst = 1'b1;
    prev_stall = 1'b0;
    bus.in_valid = 1'b0;  bus.X_s = '0;  bus.Fresh = '0;  bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.X_s = '0; bus2.Fresh = '0; bus2.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
    chk("rst_y_zero", 64'(bus.Y_s == '0), 64'd1);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("d2_rst_out_valid", 64'(bus2.out_valid), 64'd0);
    @(posedge clk);
    #1;

    // Single beat, lane0 x=0 as shares 5/5: latency and occupancy
    reset_counts();
    xs = '0;
    xs[3:0]   = 4'h5;
    xs[67:64] = 4'h5;
    lat = 0;
    occ_at1 = -1;
    cyc(1'b1, 64'h0, xs, 1'b1, acc);
    chk("t1_accept", 64'(acc), 64'd1);
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b0, 64'h0, mask1(64'h0), 1'b1, acc);
      if (i == 1) occ_at1 = int'(last_occ);
      if (ov_seen && lat == 0) lat = i;
    end
    chk("t1_latency", 64'(lat), 64'd5);
    chk("t1_occ_first", 64'(occ_at1), 64'd1);
    chk("t1_outputs", 64'(n_out), 64'd1);

    // Exhaustive: lane l carries (k+l) mod 16, back-to-back
    reset_counts();
    for (int k = 0; k < 16; k++) begin
      for (int l = 0; l < 16; l++) xv[4*l +: 4] = 4'((k + l) % 16);
      cyc(1'b1, xv, mask1(xv), 1'b1, acc);
      chk("exh_accept", 64'(acc), 64'd1);
    end
    for (int i = 0; i < 8; i++) cyc(1'b0, 64'h0, 128'h0, 1'b1, acc);
    chk("exh_outputs", 64'(n_out), 64'd16);
    chk("exh_back_to_back", 64'(last_out - first_out), 64'd15);
    chk("exh_first_cycle", 64'(first_out), 64'd5);

    // Back-pressure: 8 beats, out_ready low for cycles 6..9
    reset_counts();
    idx = 0;
    for (int cn = 0; cn < 30; cn++) begin
      for (int l = 0; l < 16; l++) xv[4*l +: 4] = 4'($urandom_range(0, 15));
      cyc(idx < 8, xv, mask1(xv), !(cn >= 6 && cn < 10), acc);
      if (acc) idx++;
      if (cn >= 6 && cn < 10) begin
        chk("bp_occ5", 64'(last_occ), 64'd5);
        chk("bp_in_ready0", 64'(last_irdy), 64'd0);
      end
    end
    chk("bp_accepted", 64'(idx), 64'd8);
    chk("bp_outputs", 64'(n_out), 64'd8);
    chk("bp_q_empty", 64'(q.size()), 64'd0);

    // Steady state: accept and emit every cycle, occupancy pinned at 5
    reset_counts();
    for (int cn = 0; cn < 22; cn++) begin
      for (int l = 0; l < 16; l++) xv[4*l +: 4] = 4'($urandom_range(0, 15));
      cyc(cn < 14, xv, mask1(xv), 1'b1, acc);
      if (cn >= 5 && cn < 14) chk("steady_occ5", 64'(last_occ), 64'd5);
    end
    chk("steady_outputs", 64'(n_out), 64'd14);

    // Reset with 3 beats in flight
    reset_counts();
    for (int k = 0; k < 3; k++) begin
      for (int l = 0; l < 16; l++) xv[4*l +: 4] = 4'($urandom_range(0, 15));
      cyc(1'b1, xv, mask1(xv), 1'b1, acc);
    end
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mrst_y_zero", 64'(bus.Y_s == '0), 64'd1);
    chk("mrst_occupancy", 64'(bus.occupancy), 64'd0);
    q.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) cyc(1'b0, 64'h0, 128'h0, 1'b1, acc);
    chk("mrst_no_stale", 64'(n_out), 64'd0);

    // Second-order, 4-lane instance: all 16 inputs per lane, 3 random shares
    idx2 = 0;
    for (int k = 0; k < 26; k++) begin
      if (k < 16) begin
        for (int l = 0; l < 4; l++) xv2[4*l +: 4] = 4'((k + l) % 16);
        xv = sbox64({48'h0, xv2});
        exp2[k] = xv[15:0];
      end
      fr2 = {16'($urandom), $urandom};
      bus2.in_valid  = (k < 16);
      bus2.X_s       = mask2(xv2);
      bus2.Fresh     = fr2;
      bus2.out_ready = 1'b1;
      @(negedge clk);
      if (bus2.out_valid) begin
        y2 = bus2.Y_s[15:0] ^ bus2.Y_s[31:16] ^ bus2.Y_s[47:32];
        if (idx2 < 16) chk("d2_y_unmask", 64'(y2), 64'(exp2[idx2]));
        idx2++;
      end
      @(posedge clk);
      #1;
    end
    bus2.in_valid = 1'b0;
    chk("d2_outputs", 64'(idx2), 64'd16);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
